// File: rtl/pc_sel_pkg.sv
// Shared PC-select codes, fetch FSM state encoding and reset vector.
package pc_sel_pkg;

  // Redirect target selects; unlisted codes fall back to sequential.
  localparam logic [2:0] PC_SEQ = 3'd0;
  localparam logic [2:0] PC_BEQ = 3'd1;
  localparam logic [2:0] PC_JAL = 3'd2;
  localparam logic [2:0] PC_JR  = 3'd3;
  localparam logic [2:0] PC_J   = 3'd4;

  // Word address of the first fetch (byte address 0x0000_3000).
  localparam logic [29:0] RESET_PC = 30'h0000_0C00;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller and imem.
interface pc_fetch_ctrl_if;

  logic        imem_req_valid;
  logic [29:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/npc_target.sv
// Combinational redirect-target mux for the word-addressed PC (mod 2^30 arithmetic).
module npc_target
  import pc_sel_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [29:0] base_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs,
  output logic [29:0] target
);

  logic [29:0] seq_pc;
  logic        unused_rs_lsbs;

  assign seq_pc = base_pc + 30'd1;

  // rs is a byte address; its low two bits carry no word information.
  assign unused_rs_lsbs = ^rs[1:0];

  // Select the next PC for the redirecting instruction.
  always_comb begin
    target = seq_pc;
    case (sel)
      PC_BEQ:       target = seq_pc + {{14{imm16[15]}}, imm16};
      PC_J, PC_JAL: target = {base_pc[29:26], target26};
      PC_JR:        target = rs[31:2];
      default:      target = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem request at a time, holds the
// fetched instruction for decode and applies execute-stage redirects.
module pc_fetch_ctrl
  import pc_sel_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  pc_fetch_ctrl_if.master    imem,
  output logic               instr_valid,
  output logic [31:0]        instr,
  output logic [29:0]        instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [2:0]         redirect_sel,
  input  logic [29:0]        redirect_base_pc,
  input  logic [15:0]        redirect_imm16,
  input  logic [25:0]        redirect_target26,
  input  logic [31:0]        redirect_rs,
  output logic [15:0]        fetch_count
);

  fetch_state_e state_q;
  logic [29:0]  pc_q;
  logic         req_valid_q;
  logic         kill_q;
  logic         instr_valid_q;
  logic [31:0]  instr_q;
  logic [29:0]  instr_pc_q;
  logic [15:0]  fetch_count_q;

  logic [29:0]  redirect_target;
  logic         accept;
  logic         kill_set;

  npc_target u_npc_target (
    .sel      (redirect_sel),
    .base_pc  (redirect_base_pc),
    .imm16    (redirect_imm16),
    .target26 (redirect_target26),
    .rs       (redirect_rs),
    .target   (redirect_target)
  );

  assign accept = (state_q == StReq) && req_valid_q && imem.imem_req_ready;

  // A redirect this cycle leaves a response in flight that must be discarded.
  always_comb begin
    kill_set = 1'b0;
    case (state_q)
      StReq:   kill_set = accept || (kill_q && !imem.imem_rsp_valid);
      StWait:  kill_set = !imem.imem_rsp_valid;
      default: kill_set = 1'b0;
    endcase
  end

  // Fetch FSM with PC, held instruction, kill flag and delivery counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      req_valid_q   <= 1'b0;
      kill_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fetch_count_q <= '0;
    end else if (redirect_valid && (state_q != StIdle)) begin
      // Redirect outranks both a returning response and a decode consume.
      state_q       <= StReq;
      pc_q          <= redirect_target;
      instr_valid_q <= 1'b0;
      kill_q        <= kill_set;
      req_valid_q   <= !kill_set;
    end else begin
      case (state_q)
        StIdle: begin
          state_q     <= StReq;
          req_valid_q <= 1'b1;
        end
        StReq: begin
          if (kill_q) begin
            if (imem.imem_rsp_valid) begin
              kill_q      <= 1'b0;
              req_valid_q <= 1'b1;
            end
          end else if (imem.imem_req_ready) begin
            state_q     <= StWait;
            req_valid_q <= 1'b0;
          end
        end
        StWait: begin
          if (imem.imem_rsp_valid) begin
            state_q       <= StHold;
            instr_q       <= imem.imem_rsp_data;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (instr_ready) begin
            state_q       <= StReq;
            instr_valid_q <= 1'b0;
            pc_q          <= pc_q + 30'd1;
            fetch_count_q <= fetch_count_q + 16'd1;
            req_valid_q   <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_req_addr  = pc_q;
  assign instr_valid         = instr_valid_q;
  assign instr               = instr_q;
  assign instr_pc            = instr_pc_q;
  assign fetch_count         = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed and randomized bench for pc_fetch_ctrl with a transaction-level model.
module tb_pc_fetch_ctrl;
  import pc_sel_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if imem_bus ();

  logic        instr_valid;
  logic [31:0] instr;
  logic [29:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [2:0]  redirect_sel = 3'd0;
  logic [29:0] redirect_base_pc = '0;
  logic [15:0] redirect_imm16 = '0;
  logic [25:0] redirect_target26 = '0;
  logic [31:0] redirect_rs = '0;
  logic [15:0] fetch_count;

  pc_fetch_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem              (imem_bus),
    .instr_valid       (instr_valid),
    .instr             (instr),
    .instr_pc          (instr_pc),
    .instr_ready       (instr_ready),
    .redirect_valid    (redirect_valid),
    .redirect_sel      (redirect_sel),
    .redirect_base_pc  (redirect_base_pc),
    .redirect_imm16    (redirect_imm16),
    .redirect_target26 (redirect_target26),
    .redirect_rs       (redirect_rs),
    .fetch_count       (fetch_count)
  );

  int unsigned n_vec = 0;
  int unsigned n_fail = 0;

  // Model: where the next fetch must go and what decode must be holding.
  logic [29:0] exp_pc;
  bit          exp_valid;
  logic [31:0] exp_instr;
  logic [29:0] exp_ipc;
  logic [15:0] exp_count;
  bit          started;
  bit          dut_out;     // controller has a request awaiting its response
  bit          pend_stale;  // that response belongs to an abandoned path
  logic [29:0] pend_addr;

  // Memory responder state and knobs.
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [29:0] mem_addr = '0;
  int unsigned ready_pct = 100;
  int unsigned ir_pct = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (a == 30'hC00) return 32'h2008_0005;
    return {a, 2'b01} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [29:0] ref_target(input logic [2:0] sel, input logic [29:0] base,
                                             input logic [15:0] imm, input logic [25:0] t26,
                                             input logic [31:0] rs);
    longint b;
    longint off;
    b   = longint'(base);
    off = longint'($signed(imm));
    case (sel)
      3'd1:       return 30'(b + 1 + off);
      3'd2, 3'd4: return 30'(((b >> 26) << 26) + longint'(t26));
      3'd3:       return 30'(rs / 4);
      default:    return 30'(b + 1);
    endcase
  endfunction

  function automatic bit exp_req_valid();
    return started && !exp_valid && !dut_out;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("req_valid", 32'(imem_bus.imem_req_valid), 32'(exp_req_valid()));
    chk("req_addr", 32'(imem_bus.imem_req_addr), 32'(exp_pc));
    chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
    chk("instr", instr, exp_instr);
    chk("instr_pc", 32'(instr_pc), 32'(exp_ipc));
    chk("fetch_count", 32'(fetch_count), 32'(exp_count));
  endtask

  task automatic model_reset();
    exp_pc     = RESET_PC;
    exp_valid  = 1'b0;
    exp_instr  = '0;
    exp_ipc    = '0;
    exp_count  = '0;
    started    = 1'b0;
    dut_out    = 1'b0;
    pend_stale = 1'b0;
    pend_addr  = '0;
  endtask

  // Asynchronous reset mid-cycle; outputs must drop before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
    chk("rst_req_addr", 32'(imem_bus.imem_req_addr), 32'h0000_0C00);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_fetch_count", 32'(fetch_count), 32'd0);
  endtask

  task automatic set_redirect(input logic [2:0] sel, input logic [29:0] base,
                              input logic [15:0] imm, input logic [25:0] t26,
                              input logic [31:0] rs);
    redirect_valid    = 1'b1;
    redirect_sel      = sel;
    redirect_base_pc  = base;
    redirect_imm16    = imm;
    redirect_target26 = t26;
    redirect_rs       = rs;
  endtask

  // One clock: check outputs, drive memory/decode, advance model, cross the edge.
  task automatic step_cycle();
    bit rsp, rd, accept, got, deliver, consume, mem_acc;
    logic [29:0] pc_now;
    check_outputs();
    rsp = mem_busy && (mem_cnt == 0);
    imem_bus.imem_rsp_valid = rsp;
    imem_bus.imem_rsp_data  = rsp ? mem_word(mem_addr) : $urandom();
    imem_bus.imem_req_ready = !mem_busy && ($urandom_range(99) < ready_pct);
    instr_ready = ($urandom_range(99) < ir_pct);
    mem_acc = imem_bus.imem_req_valid && imem_bus.imem_req_ready;
    if (rst_n) begin
      rd      = redirect_valid && started;
      accept  = exp_req_valid() && imem_bus.imem_req_ready;
      got     = rsp && dut_out;
      deliver = got && !pend_stale && !rd;
      consume = exp_valid && instr_ready && !rd;
      pc_now  = exp_pc;
      if (deliver) begin
        exp_valid = 1'b1;
        exp_instr = mem_word(pend_addr);
        exp_ipc   = pend_addr;
      end
      if (got) dut_out = 1'b0;
      if (accept) begin
        dut_out    = 1'b1;
        pend_addr  = pc_now;
        pend_stale = rd;
      end else if (rd && dut_out) begin
        pend_stale = 1'b1;
      end
      if (consume) begin
        exp_valid = 1'b0;
        exp_pc    = pc_now + 30'd1;
        exp_count = exp_count + 16'd1;
      end
      if (rd) begin
        exp_valid = 1'b0;
        exp_pc = ref_target(redirect_sel, redirect_base_pc, redirect_imm16, redirect_target26,
                            redirect_rs);
      end
      started = 1'b1;
    end
    if (rsp) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (mem_acc) begin
      mem_busy = 1'b1;
      mem_addr = imem_bus.imem_req_addr;
      mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    imem_bus.imem_req_ready = 1'b0;
    imem_bus.imem_rsp_valid = 1'b0;
    imem_bus.imem_rsp_data  = '0;
    model_reset();

    // Reset values, then release with zero-wait memory.
    #2;
    do_reset();
    step_cycle();
    step_cycle();
    rst_n = 1'b1;
    set_redirect(PC_JR, 30'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);  // lands in IDLE: ignored
    step_cycle();
    step_cycle();
    step_cycle();
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_instr", instr, 32'h2008_0005);
    chk("first_pc", 32'(instr_pc), 32'h0000_0C00);
    ir_pct = 100;
    ready_pct = 0;
    step_cycle();
    chk("next_req_valid", 32'(imem_bus.imem_req_valid), 32'd1);
    chk("next_req_addr", 32'(imem_bus.imem_req_addr), 32'h0000_0C01);

    // Redirect target arithmetic.
    set_redirect(PC_BEQ, 30'hC00, 16'hFFFE, 26'h0, 32'h0);
    step_cycle();
    chk("beq_addr", 32'(imem_bus.imem_req_addr), 32'h0000_0BFF);
    chk("beq_valid", 32'(imem_bus.imem_req_valid), 32'd1);
    set_redirect(PC_J, 30'h3000_0C00, 16'h0, 26'h0000C10, 32'h0);
    step_cycle();
    chk("j_addr", 32'(imem_bus.imem_req_addr), 32'h3000_0C10);
    set_redirect(PC_JR, 30'h0, 16'h0, 26'h0, 32'h0000_3043);
    step_cycle();
    chk("jr_addr", 32'(imem_bus.imem_req_addr), 32'h0000_0C10);

    // Redirect in WAIT with a 3-cycle response: stale response is dropped.
    ready_pct = 100;
    ir_pct = 0;
    lat_min = 3;
    lat_max = 3;
    step_cycle();
    set_redirect(PC_SEQ, 30'h100, 16'h0, 26'h0, 32'h0);
    step_cycle();
    chk("kill_req_low0", 32'(imem_bus.imem_req_valid), 32'd0);
    step_cycle();
    chk("kill_req_low1", 32'(imem_bus.imem_req_valid), 32'd0);
    step_cycle();
    chk("kill_req_high", 32'(imem_bus.imem_req_valid), 32'd1);
    chk("kill_req_addr", 32'(imem_bus.imem_req_addr), 32'h0000_0101);
    chk("kill_no_instr", 32'(instr_valid), 32'd0);

    // Decode stall in HOLD, then redirect together with instr_ready.
    lat_min = 1;
    lat_max = 1;
    step_cycle();
    step_cycle();
    for (int i = 0; i < 5; i++) step_cycle();
    chk("stall_pc", 32'(instr_pc), 32'h0000_0101);
    chk("stall_count", 32'(fetch_count), 32'd1);
    chk("stall_no_req", 32'(imem_bus.imem_req_valid), 32'd0);
    ir_pct = 100;
    ready_pct = 0;
    set_redirect(PC_JAL, 30'h0000_0C00, 16'h0, 26'h0000ABC, 32'h0);
    step_cycle();
    chk("race_count", 32'(fetch_count), 32'd1);
    chk("race_addr", 32'(imem_bus.imem_req_addr), 32'h0000_0ABC);
    chk("race_valid", 32'(imem_bus.imem_req_valid), 32'd1);

    // Reset mid-WAIT; the late response must not be delivered.
    ir_pct = 0;
    ready_pct = 100;
    lat_min = 6;
    lat_max = 6;
    step_cycle();
    step_cycle();
    do_reset();
    lat_min = 1;
    lat_max = 1;
    step_cycle();
    step_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step_cycle();
    chk("restart_valid", 32'(instr_valid), 32'd1);
    chk("restart_instr", instr, 32'h2008_0005);
    chk("restart_pc", 32'(instr_pc), 32'h0000_0C00);

    // Randomized traffic with redirects landing in every state.
    ready_pct = 60;
    ir_pct = 50;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        step_cycle();
        rst_n = 1'b1;
      end
      if ($urandom_range(99) < 12)
        set_redirect(3'($urandom_range(7)), 30'($urandom()), 16'($urandom()),
                     26'($urandom()), $urandom());
      step_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch sequencer for the MIPS core's word-addressed program counter. It owns the PC register and issues one instruction-memory request at a time over a valid/ready handshake. It hands each fetched instruction to decode and applies redirects (beq, j, jal, jr) from the execute stage. Redirects kill any in-flight fetch. It replaces the free-running PC update with a sequenced, stall-aware controller.

## Interface
- RESET_PC, 30'h0000_0C00, word address loaded at reset (byte 0x0000_3000)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  30  word address of the fetch
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_rsp_valid  in  1  instruction word returned, one cycle pulse
- imem_rsp_data  in  32  returned instruction
- instr_valid  out  1  instruction available to decode
- instr  out  32  held instruction
- instr_pc  out  30  word address of the held instruction
- instr_ready  in  1  decode consumes instr this cycle
- redirect_valid  in  1  control-flow change, one cycle pulse
- redirect_sel  in  3  PC_SEQ=0, PC_BEQ=1, PC_JAL=2, PC_JR=3, PC_J=4; other codes behave as PC_SEQ
- redirect_base_pc  in  30  word PC of the redirecting instruction
- redirect_imm16  in  16  branch offset in words, signed
- redirect_target26  in  26  jump target field
- redirect_rs  in  32  jr register value (byte address)
- fetch_count  out  16  instructions delivered to decode, wraps

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: entered only from reset. Moves to REQ on the first clock after rst_n deasserts.
- REQ: imem_req_valid=1 and imem_req_addr=pc. On imem_req_ready, move to WAIT.
- WAIT: on imem_rsp_valid, capture imem_rsp_data into instr, capture pc into instr_pc, set instr_valid, and move to HOLD.
- HOLD: on instr_ready, clear instr_valid, set pc=pc+1, increment fetch_count, and move to REQ.
- Redirect target computation:
  - PC_SEQ: base+1.
  - PC_BEQ: base+1+sign-extend(imm16) to 30 bits.
  - PC_J and PC_JAL: {base[29:26], target26}.
  - PC_JR: rs[31:2]; rs[1:0] is ignored.
  - Mod-2^30 wrap in all cases.
- Redirect in any state other than IDLE:
  - pc loads the target.
  - instr_valid clears; instr and instr_pc keep their old values.
  - State becomes REQ.
  - If a request is outstanding, or is accepted in the redirect cycle, a kill flag is set.
- Redirect in IDLE: ignored.
- While the kill flag is set:
  - The next imem_rsp_valid is dropped and the kill flag clears.
  - REQ holds imem_req_valid=0 until the killed response returns, so there is never more than one outstanding request.
- imem_rsp_valid while not in WAIT and with no kill pending: ignored.
- Simultaneous redirect_valid and instr_ready in HOLD: redirect wins; fetch_count is not incremented.
- Simultaneous redirect_valid and imem_rsp_valid in WAIT: the response is dropped, the kill flag is not set, and the state goes to REQ at the target.

## Timing
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fetch_count=0, kill=0, state IDLE.
- All outputs are registered. imem_req_addr is a direct copy of the pc register.
- Fetch latency with zero-wait memory (ready=1, rsp on the cycle after accept):
  - Cycle 0: REQ.
  - Cycle 1: WAIT, rsp arrives.
  - Cycle 2: instr_valid=1.
  - Best-case throughput is one instruction every 3 cycles.
- The redirect takes effect on the next edge: imem_req_valid=1 at the target in the following cycle, unless a kill is pending.
- rst_n assertion mid-operation returns all state to the reset values immediately. Any response arriving during or after reset is ignored.

## Structure
- Package pc_sel_pkg holds:
  - the PC_* select constants;
  - the state encoding (2-bit enum);
  - the RESET_PC default.
- Sub-module npc_target holds the combinational redirect-target mux. It is shared with other PC datapath users.
- pc_fetch_ctrl contains the FSM, the pc, instr and instr_pc registers, the kill flag, and fetch_count.

## Test plan
- Reset release with ready=1 and 1-cycle response returning 32'h2008_0005 -> first request at address 30'hC00, then instr_valid with instr=32'h2008_0005 and instr_pc=30'hC00; after instr_ready, next request at 30'hC01.
- Redirect PC_BEQ with base=30'hC00 and imm16=16'hFFFE -> next request address 30'hBFF.
- Redirect PC_J with base=30'h3000_0C00 and target26=26'h0000C10 -> next request address 30'h3000_0C10. Redirect PC_JR with rs=32'h0000_3043 -> next request address 30'hC10.
- Redirect while in WAIT with the response delayed 3 cycles:
  - The stale response is dropped and instr_valid stays 0.
  - imem_req_valid stays low until the stale response returns, then asserts at the target.
- Hold instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc stable, no new request, fetch_count unchanged. Then pulse redirect_valid together with instr_ready=1 -> fetch_count not incremented, next request at the target.
- Assert rst_n low mid-WAIT -> all outputs at reset values in the same cycle; a response arriving afterwards is ignored; fetch restarts at 30'hC00.
